// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional feature macro used by this block: SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width; floored at 1 so a counter always exists.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake between the issuing controller and the serial adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag to the result side.
interface serial_adder_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             C_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, A, B, C_in, input busy, done, sum, C_out, ovf);
    modport slave  (input start, A, B, C_in, output busy, done, sum, C_out, ovf);
`else
    modport master (output start, A, B, C_in, input busy, done, sum, C_out);
    modport slave  (input start, A, B, C_in, output busy, done, sum, C_out);
`endif
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared with the parallel adder family.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic sum,
    output logic carry
);
    assign sum   = A ^ B ^ C;
    assign carry = (A & B) | (C & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder step per clock, LSB first, start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_next;

    full_adder u_fa (
        .A     (a_sh[0]),
        .B     (b_sh[0]),
        .C     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Each result bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB.
    assign res_next = {fa_sum, res_sh[WIDTH-1:1]};

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are cleared too, so an aborted operation leaves no residue.
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.sum   <= '0;
            bus.C_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            bus.ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.A;
                        b_sh     <= bus.B;
                        carry    <= bus.C_in;
                        res_sh   <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        state    <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_carry;
                    res_sh <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.sum   <= res_next;
                        bus.C_out <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB during the last step.
                        bus.ovf   <= carry ^ fa_carry;
`endif
                        state     <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=4), plus an exhaustive operand sweep.
// Exercises the ovf output when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();
    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after capture, wait for done (bounded).
    // Returns at the sampling point of the done cycle; lat is cycles after the accept edge.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                          output logic [WIDTH-1:0] s, output logic co,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.C_in  = cin;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.C_in  = ~cin;
        lat = 1;
        busy_cycles = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        s  = bus.sum;
        co = bus.C_out;
    endtask

    initial begin
        logic [WIDTH-1:0] s;
        logic             co;
        int               lat;
        int               bcyc;
        int               ndone;
        int               first_cyc;
        int               second_cyc;
        logic [WIDTH-1:0] first_sum;
        logic [WIDTH-1:0] second_sum;
        logic [WIDTH-1:0] held_sum;
        logic [4:0]       exp5;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.C_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_sum", 32'(bus.sum), 0);
        check("reset_cout", 32'(bus.C_out), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_ovf", 32'(bus.ovf), 0);
`endif

        // 3 + 5: latency and busy window
        run_op(4'd3, 4'd5, 1'b0, s, co, lat, bcyc);
        check("add3_5_sum", 32'(s), 8);
        check("add3_5_cout", 32'(co), 0);
        check("add3_5_latency", 32'(lat), 5);
        check("add3_5_busy_cycles", 32'(bcyc), 4);
        check("busy_at_done", 32'(bus.busy), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 0);
        check("sum_held", 32'(bus.sum), 8);

        run_op(4'd15, 4'd1, 1'b0, s, co, lat, bcyc);
        check("add15_1_sum", 32'(s), 0);
        check("add15_1_cout", 32'(co), 1);
        run_op(4'd15, 4'd15, 1'b1, s, co, lat, bcyc);
        check("add15_15_1_sum", 32'(s), 15);
        check("add15_15_1_cout", 32'(co), 1);

        // start while busy is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd2; bus.B = 4'd2; bus.C_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd9; bus.B = 4'd9;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0; first_cyc = 0; first_sum = '0;
        for (int cyc = 3; cyc <= 15; cyc++) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    first_cyc = cyc;
                    first_sum = bus.sum;
                end
            end
            @(negedge clk);
        end
        check("busy_start_done_count", 32'(ndone), 1);
        check("busy_start_done_cycle", 32'(first_cyc), 5);
        check("busy_start_sum", 32'(first_sum), 4);
        check("busy_start_cout", 32'(bus.C_out), 0);

        // back-to-back: start held through DONE
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd1; bus.B = 4'd1; bus.C_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.A = 4'd6; bus.B = 4'd7;
        ndone = 0; first_cyc = 0; second_cyc = 0;
        first_sum = '0; second_sum = '0; held_sum = '0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    first_cyc = cyc;
                    first_sum = bus.sum;
                end else begin
                    second_cyc = cyc;
                    second_sum = bus.sum;
                end
            end
            if (cyc == 6) bus.start = 1'b0;
            if (cyc == 7) held_sum = bus.sum;
            @(negedge clk);
        end
        check("b2b_done_count", 32'(ndone), 2);
        check("b2b_first_cycle", 32'(first_cyc), 5);
        check("b2b_second_cycle", 32'(second_cyc), 10);
        check("b2b_first_sum", 32'(first_sum), 2);
        check("b2b_second_sum", 32'(second_sum), 13);
        check("b2b_sum_held", 32'(held_sum), 2);

        // reset mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd5; bus.B = 4'd6;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_sum", 32'(bus.sum), 0);
        check("abort_cout", 32'(bus.C_out), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("abort_ovf", 32'(bus.ovf), 0);
`endif
        ndone = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(ndone), 0);
        run_op(4'd4, 4'd4, 1'b0, s, co, lat, bcyc);
        check("after_abort_sum", 32'(s), 8);
        check("after_abort_cout", 32'(co), 0);

        // rst and start together: rst wins
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.A = 4'd3; bus.B = 4'd3;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 0);
        check("rst_start_sum", 32'(bus.sum), 0);
        ndone = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        check("rst_start_no_done", 32'(ndone), 0);

`ifdef SERIAL_ADDER_OVF_EN
        run_op(4'd7, 4'd1, 1'b0, s, co, lat, bcyc);
        check("ovf7_1_sum", 32'(s), 8);
        check("ovf7_1_cout", 32'(co), 0);
        check("ovf7_1_ovf", 32'(bus.ovf), 1);
        run_op(4'd15, 4'd1, 1'b0, s, co, lat, bcyc);
        check("ovf15_1_ovf", 32'(bus.ovf), 0);
`endif

        // exhaustive sweep against the arithmetic model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op(WIDTH'(a), WIDTH'(b), 1'(c), s, co, lat, bcyc);
                    exp5 = 5'(a + b + c);
                    check($sformatf("sweep_%0d_%0d_%0d", a, b, c), 32'({co, s}), 32'(exp5));
`ifdef SERIAL_ADDER_OVF_EN
                    check($sformatf("sweep_ovf_%0d_%0d_%0d", a, b, c), 32'(bus.ovf),
                          32'((((a & 7) + (b & 7) + c) >> 3) ^ int'(exp5[4])));
`endif
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
